// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_pkg
//  Description : Shared types and constants for the Avalon-MM master and the
//                8-bit packet-control register slave it drives.
//                Contents: response codes, master FSM states, register map,
//                VERSION reset value, address range helper.
//  Revision    : 1.0  initial release
// ============================================================================
package avalon_pkg;

    // Response code returned on the command/response port
    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_DECERR  = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_t;

    // Master sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Register map of the packet-control slave
    localparam logic [7:0] REG_NUMPKTS   = 8'd0;
    localparam logic [7:0] REG_START     = 8'd1;
    localparam logic [7:0] REG_STOP      = 8'd2;
    localparam logic [7:0] REG_PKTLENGTH = 8'd3;
    localparam logic [7:0] REG_PAYLOAD   = 8'd4;
    localparam logic [7:0] REG_VERSION   = 8'd5;
    localparam logic [7:0] REG_SCRATCH   = 8'd6;

    localparam logic [7:0] VERSION_RESET = 8'h12;

    // True when addr names one of the first num_regs registers
    function automatic logic addr_in_range(input logic [7:0] addr, input int num_regs);
        return ({24'd0, addr} < num_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_counter
//  Description : Loadable down-counter with a zero flag. Decrement stops at 0.
//  Ports       : clk, reset (async, active-low), load, load_value[W-1:0],
//                dec, zero
//  Revision    : 1.0  initial release
// ============================================================================
module cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/avalon_master.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_master
//  Description : Avalon-MM master for the 8-bit packet-control register slave.
//                Accepts one command at a time, runs one read or write bus
//                cycle honouring waitrequest (with a bus timeout), returns a
//                one-cycle response, then holds the bus idle for IDLE_GAP
//                cycles so the slave's delay lines drain.
//  Ports       : clk, reset (async, active-low)
//                cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command in
//                rsp_valid/rsp_code/rsp_rdata                      response out
//                address/read/write/writedata/readdata/waitrequest Avalon-MM
//  Revision    : 1.0  initial release
// ============================================================================
module avalon_master
    import avalon_pkg::*;
#(
    parameter int NUM_REGS = 7,
    parameter int TIMEOUT  = 16,
    parameter int IDLE_GAP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_code,
    output logic [7:0] rsp_rdata,
    output logic [7:0] address,
    output logic       read,
    output logic       write,
    output logic [7:0] writedata,
    input  logic [7:0] readdata,
    input  logic       waitrequest
);

    localparam int TO_W  = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    // Counters hold "edges remaining": a load of N-1 makes zero true on the Nth edge
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    state_t     state;
    state_t     state_nxt;

    logic       accept;
    logic       addr_ok;
    logic       bus_done;

    logic       cmd_ready_nxt;
    logic       rsp_valid_nxt;
    rsp_t       rsp_code_nxt;
    logic [7:0] rsp_rdata_nxt;
    logic [7:0] address_nxt;
    logic       read_nxt;
    logic       write_nxt;
    logic [7:0] writedata_nxt;

    logic       to_load;
    logic       to_dec;
    logic       to_zero;
    logic       gap_load;
    logic       gap_dec;
    logic       gap_zero;

    assign accept   = cmd_valid && cmd_ready;
    assign addr_ok  = addr_in_range(cmd_addr, NUM_REGS);
    // Completion takes priority over timeout on the same edge
    assign bus_done = !waitrequest || to_zero;

    cycle_counter #(.W(TO_W)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (to_load),
        .load_value (TO_LOAD),
        .dec        (to_dec),
        .zero       (to_zero)
    );

    cycle_counter #(.W(GAP_W)) u_gap (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .dec        (gap_dec),
        .zero       (gap_zero)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_code  <= 2'b00;
            rsp_rdata <= 8'h00;
            address   <= 8'h00;
            read      <= 1'b0;
            write     <= 1'b0;
            writedata <= 8'h00;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_code  <= rsp_code_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            address   <= address_nxt;
            read      <= read_nxt;
            write     <= write_nxt;
            writedata <= writedata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && addr_ok) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (bus_done) begin
                    state_nxt = (IDLE_GAP == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Next values of the registered outputs and counter controls
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_code_nxt  = RSP_OK;
        rsp_rdata_nxt = 8'h00;
        address_nxt   = address;
        read_nxt      = read;
        write_nxt     = write;
        writedata_nxt = writedata;
        to_load       = 1'b0;
        to_dec        = 1'b0;
        gap_load      = 1'b0;
        gap_dec       = 1'b0;

        case (state)
            IDLE: begin
                // cmd_ready drops for one cycle after any accept, so a response
                // cycle never overlaps a new accept and responses never abut
                cmd_ready_nxt = !accept;
                if (accept) begin
                    if (addr_ok) begin
                        address_nxt   = cmd_addr;
                        writedata_nxt = cmd_wdata;
                        read_nxt      = !cmd_write;
                        write_nxt     = cmd_write;
                        to_load       = 1'b1;
                    end else begin
                        rsp_valid_nxt = 1'b1;
                        rsp_code_nxt  = RSP_DECERR;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_nxt      = 1'b0;
                    write_nxt     = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_code_nxt  = RSP_OK;
                    rsp_rdata_nxt = read ? readdata : 8'h00;
                    gap_load      = 1'b1;
                end else if (to_zero) begin
                    read_nxt      = 1'b0;
                    write_nxt     = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_code_nxt  = RSP_TIMEOUT;
                    gap_load      = 1'b1;
                end else begin
                    to_dec = 1'b1;
                end
            end
            GAP: begin
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
                if (gap_zero) begin
                    cmd_ready_nxt = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
